// File: rtl/pet_video_pkg.sv
// Shared types and constants for the PET character pixel pipeline.
package pet_video_pkg;

    localparam int CHAR_W     = 8;   // pixels per character cell / ROM row width
    localparam int CHARADDR_W = 11;  // {gfx, code[6:0], row[2:0]}
    localparam int PIPE_CHARS = 2;   // character slots between matrix fetch and first pixel

    // Timing/control flags that travel down the pipeline alongside the pixels.
    typedef struct packed {
        logic de;
        logic cursor;
        logic hsync;
        logic vsync;
        logic hblank;
        logic vblank;
    } vid_ctl_t;

    // Character-ROM address: charset select, character code, raster row.
    function automatic logic [CHARADDR_W-1:0] make_charaddr(
        input logic       gfx,
        input logic [6:0] code,
        input logic [2:0] row
    );
        return {gfx, code, row};
    endfunction

endpackage

// File: rtl/pet_blink_counter.sv
// Cursor blink generator: counts vsync rising edges and toggles the blink
// phase every BLINK_FRAMES frames.
module pet_blink_counter #(
    parameter int BLINK_FRAMES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic ce_pix,
    input  logic vsync,
    output logic blink
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(BLINK_FRAMES - 1);

    logic             vsync_prev_reg;
    logic [CNT_W-1:0] count_reg;
    logic             blink_reg;
    logic             vsync_rise;

    // vsync is only looked at on pixel enables, matching the upstream timing
    assign vsync_rise = ce_pix & vsync & ~vsync_prev_reg;

    // Frame counter with wrap; the blink phase flips on each wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_prev_reg <= 1'b0;
            count_reg      <= '0;
            blink_reg      <= 1'b0;
        end else begin
            if (ce_pix) begin
                vsync_prev_reg <= vsync;
            end
            if (vsync_rise) begin
                if (count_reg == LAST_FRAME) begin
                    count_reg <= '0;
                    blink_reg <= ~blink_reg;
                end else begin
                    count_reg <= count_reg + 1'b1;
                end
            end
        end
    end

    assign blink = blink_reg;

endmodule

// File: rtl/pet_char_shifter.sv
// PET pixel stage: fetches the character-ROM row for each screen-matrix byte,
// serialises it MSB first with reverse-video / cursor / blanking, and delays
// the timing flags by the same two character slots so everything stays aligned.
module pet_char_shifter
    import pet_video_pkg::*;
#(
    parameter int BLINK_FRAMES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce_pix,
    input  logic                  char_load,
    input  logic [7:0]            video_data,
    input  logic [4:0]            vid_ra,
    input  logic                  vid_de,
    input  logic                  vid_cursor,
    input  logic                  vid_hsync,
    input  logic                  vid_vsync,
    input  logic                  vid_hblank,
    input  logic                  vid_vblank,
    input  logic                  video_gfx,
    input  logic                  video_blank,
    output logic [CHARADDR_W-1:0] charaddr,
    input  logic [CHAR_W-1:0]     chardata,
    output logic                  pix,
    output logic                  hsync_o,
    output logic                  vsync_o,
    output logic                  hblank_o,
    output logic                  vblank_o,
    output logic                  de_o
);

    logic                  load;
    vid_ctl_t              ctl_in;

    // Stage 0: matrix byte, ROM address, incoming flags
    logic [CHAR_W-1:0]     m_byte_reg;
    logic [CHARADDR_W-1:0] charaddr_reg;
    vid_ctl_t              ctl0_reg;

    // Stage 1: ROM row and inversion decision
    logic [CHAR_W-1:0]     row1_reg;
    logic                  inv1_reg;
    vid_ctl_t              ctl1_reg;
    logic [CHAR_W-1:0]     row1_next;
    logic                  inv1_next;

    // Stage 2: shifter and output-aligned flags
    logic [CHAR_W-1:0]     shreg_reg;
    logic [CHAR_W-1:0]     shreg_shifted;
    logic                  inv2_reg;
    vid_ctl_t              ctl2_reg;

    logic                  blink;
    logic                  unused_bits;

    assign load   = ce_pix & char_load;
    assign ctl_in = {vid_de, vid_cursor, vid_hsync, vid_vsync, vid_hblank, vid_vblank};

    pet_blink_counter #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink (
        .clk    (clk),
        .reset  (reset),
        .ce_pix (ce_pix),
        .vsync  (vid_vsync),
        .blink  (blink)
    );

    // Outside the display area the row is forced dark and never inverted,
    // so a reverse byte in the border cannot light it up.
    always_comb begin
        row1_next = ctl0_reg.de ? chardata : '0;
        inv1_next = ctl0_reg.de & (m_byte_reg[7] ^ (ctl0_reg.cursor & blink));
    end

    // Left shift with zero fill: an exhausted register shows only the inversion bit
    genvar gi;
    generate
        for (gi = 0; gi < CHAR_W; gi++) begin : g_shift
            if (gi == 0) begin : g_fill
                assign shreg_shifted[gi] = 1'b0;
            end else begin : g_bit
                assign shreg_shifted[gi] = shreg_reg[gi-1];
            end
        end
    endgenerate

    // Three-stage character pipeline; a load takes priority over the shift
    always_ff @(posedge clk) begin
        if (reset) begin
            m_byte_reg   <= '0;
            charaddr_reg <= '0;
            ctl0_reg     <= '0;
            row1_reg     <= '0;
            inv1_reg     <= 1'b0;
            ctl1_reg     <= '0;
            shreg_reg    <= '0;
            inv2_reg     <= 1'b0;
            ctl2_reg     <= '0;
        end else if (ce_pix) begin
            if (load) begin
                m_byte_reg   <= video_data;
                charaddr_reg <= make_charaddr(video_gfx, video_data[6:0], vid_ra[2:0]);
                ctl0_reg     <= ctl_in;
                row1_reg     <= row1_next;
                inv1_reg     <= inv1_next;
                ctl1_reg     <= ctl0_reg;
                shreg_reg    <= row1_reg;
                inv2_reg     <= inv1_reg;
                ctl2_reg     <= ctl1_reg;
            end else begin
                shreg_reg    <= shreg_shifted;
            end
        end
    end

    assign charaddr = charaddr_reg;
    // Blanking gates only the pixel; the timing flags still pass through
    assign pix      = (shreg_reg[CHAR_W-1] ^ inv2_reg) & ~video_blank;
    assign hsync_o  = ctl2_reg.hsync;
    assign vsync_o  = ctl2_reg.vsync;
    assign hblank_o = ctl2_reg.hblank;
    assign vblank_o = ctl2_reg.vblank;
    assign de_o     = ctl2_reg.de;

    // Upper raster-row bits, the character code after addressing, and the
    // delayed cursor flag have no consumer at the output.
    assign unused_bits = &{1'b0, vid_ra[4:3], m_byte_reg[6:0], ctl2_reg.cursor};

endmodule

// File: tb/tb_pet_char_shifter.sv
// Self-checking bench for pet_char_shifter: table of character slots with
// hand-computed results two slots later, plus blank, blink and reset sequences.
module tb_pet_char_shifter;
    import pet_video_pkg::*;

    logic        clk = 1'b0;
    logic        reset, ce_pix, char_load;
    logic [7:0]  video_data;
    logic [4:0]  vid_ra;
    logic        vid_de, vid_cursor, vid_hsync, vid_vsync, vid_hblank, vid_vblank;
    logic        video_gfx, video_blank;
    logic [10:0] charaddr;
    logic [7:0]  chardata;
    logic        pix, hsync_o, vsync_o, hblank_o, vblank_o, de_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pet_char_shifter #(.BLINK_FRAMES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .ce_pix      (ce_pix),
        .char_load   (char_load),
        .video_data  (video_data),
        .vid_ra      (vid_ra),
        .vid_de      (vid_de),
        .vid_cursor  (vid_cursor),
        .vid_hsync   (vid_hsync),
        .vid_vsync   (vid_vsync),
        .vid_hblank  (vid_hblank),
        .vid_vblank  (vid_vblank),
        .video_gfx   (video_gfx),
        .video_blank (video_blank),
        .charaddr    (charaddr),
        .chardata    (chardata),
        .pix         (pix),
        .hsync_o     (hsync_o),
        .vsync_o     (vsync_o),
        .hblank_o    (hblank_o),
        .vblank_o    (vblank_o),
        .de_o        (de_o)
    );

    // Character ROM contents used by the tests
    function automatic logic [7:0] rom_row(input logic [10:0] a);
        if (a == 11'h20B)       return 8'hA5;
        if (a[9:3] == 7'h7F)    return 8'hFF;
        return 8'h00;
    endfunction

    // One-clock synchronous ROM
    always @(posedge clk) chardata <= rom_row(charaddr);

    typedef struct {
        logic [7:0]  data;
        logic [4:0]  ra;
        logic        gfx, de, cur, hs, vs, hb, vb;
        logic [10:0] exp_addr;
        logic [7:0]  exp_pix;
        logic [4:0]  exp_ctl;   // {de, hsync, vsync, hblank, vblank} at the slot's load
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One character slot: 8 pixel enables with a disabled clock (carrying a
    // stray char_load) in the middle. Pixels collected MSB first.
    task automatic slot(input logic [7:0] data, input logic [4:0] ra,
                        input logic gfx, input logic de, input logic cur,
                        input logic hs, input logic vs, input logic hb, input logic vb,
                        input logic [7:0] blank_mask,
                        output logic [7:0] pixs, output logic [4:0] ctl,
                        output logic [10:0] addr);
        video_data = data; vid_ra = ra; video_gfx = gfx; vid_de = de;
        vid_cursor = cur; vid_hsync = hs; vid_vsync = vs; vid_hblank = hb; vid_vblank = vb;
        pixs = '0; ctl = '0; addr = '0;
        for (int p = 0; p < 8; p++) begin
            ce_pix      = 1'b1;
            char_load   = (p == 0);
            video_blank = blank_mask[7-p];
            tick();
            pixs[7-p] = pix;
            if (p == 0) begin
                ctl  = {de_o, hsync_o, vsync_o, hblank_o, vblank_o};
                addr = charaddr;
            end
            if (p == 3) begin
                ce_pix    = 1'b0;
                char_load = 1'b1;
                tick();
            end
        end
        ce_pix = 1'b0; char_load = 1'b0; video_blank = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; ce_pix = 1'b1; char_load = 1'b0;
        repeat (3) tick();
        reset = 1'b0; ce_pix = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  pixs;
        logic [4:0]  ctl;
        logic [10:0] addr;
        logic [7:0]  exp_px;

        reset = 1'b1; ce_pix = 1'b0; char_load = 1'b0;
        video_data = '0; vid_ra = '0; vid_de = 0; vid_cursor = 0;
        vid_hsync = 0; vid_vsync = 0; vid_hblank = 0; vid_vblank = 0;
        video_gfx = 0; video_blank = 0;

        // ---- reset state
        repeat (3) tick();
        check("reset_outputs", {10'd0, pix, de_o, hsync_o, vsync_o, hblank_o, vblank_o}, 16'h0000);
        check("reset_charaddr", {5'd0, charaddr}, 16'h0000);
        $display("reset: pix=%b de_o=%b charaddr=%h", pix, de_o, charaddr);
        reset = 1'b0;
        tick();

        // ---- table: result of slot i appears at slot i+2
        //          data   ra  gfx de cur hs vs hb vb  addr     pix    ctl
        vecs[0] = '{8'h41, 5'd3, 0, 1, 0, 0, 0, 0, 0, 11'h20B, 8'h00, 5'b00000};
        vecs[1] = '{8'hC1, 5'd3, 0, 1, 0, 0, 0, 0, 0, 11'h20B, 8'h00, 5'b00000};
        vecs[2] = '{8'hC1, 5'd3, 0, 0, 0, 0, 0, 0, 0, 11'h20B, 8'hA5, 5'b10000};
        vecs[3] = '{8'h7F, 5'd5, 1, 1, 0, 1, 0, 0, 0, 11'h7FD, 8'h5A, 5'b10000};
        vecs[4] = '{8'h00, 5'd0, 0, 1, 0, 1, 0, 1, 0, 11'h000, 8'h00, 5'b00000};
        vecs[5] = '{8'h41, 5'd3, 0, 0, 0, 0, 1, 0, 1, 11'h20B, 8'hFF, 5'b11000};
        vecs[6] = '{8'h20, 5'd1, 0, 1, 0, 0, 0, 0, 0, 11'h101, 8'h00, 5'b11010};
        vecs[7] = '{8'hA0, 5'd1, 0, 1, 0, 0, 0, 0, 0, 11'h101, 8'h00, 5'b00101};
        vecs[8] = '{8'h20, 5'd1, 0, 1, 0, 0, 0, 0, 0, 11'h101, 8'h00, 5'b10000};
        vecs[9] = '{8'h20, 5'd1, 0, 1, 0, 0, 0, 0, 0, 11'h101, 8'hFF, 5'b10000};

        for (int i = 0; i < 10; i++) begin
            slot(vecs[i].data, vecs[i].ra, vecs[i].gfx, vecs[i].de, vecs[i].cur,
                 vecs[i].hs, vecs[i].vs, vecs[i].hb, vecs[i].vb, 8'h00, pixs, ctl, addr);
            check($sformatf("vec%0d_charaddr", i), {5'd0, addr}, {5'd0, vecs[i].exp_addr});
            check($sformatf("vec%0d_pix", i), {8'd0, pixs}, {8'd0, vecs[i].exp_pix});
            check($sformatf("vec%0d_ctl", i), {11'd0, ctl}, {11'd0, vecs[i].exp_ctl});
            $display("vec %0d: data=%h addr=%h pix=%h ctl=%b", i, vecs[i].data, addr, pixs, ctl);
        end

        // ---- blank override on a solid glyph: first half blanked
        slot(8'h7F, 5'd0, 0, 1, 0, 0, 0, 0, 0, 8'h00, pixs, ctl, addr);
        slot(8'h20, 5'd0, 0, 1, 0, 0, 0, 0, 0, 8'h00, pixs, ctl, addr);
        slot(8'h20, 5'd0, 0, 1, 0, 0, 0, 0, 0, 8'hF0, pixs, ctl, addr);
        check("blank_pix", {8'd0, pixs}, 16'h000F);
        check("blank_ctl", {11'd0, ctl}, 16'h0010);
        $display("blank: pix=%h ctl=%b", pixs, ctl);

        // ---- cursor blink with BLINK_FRAMES=2; frame f sees f vsync edges
        do_reset();
        for (int f = 0; f < 6; f++) begin
            slot(8'h20, 5'd0, 0, 1, 1, 0, 0, 0, 0, 8'h00, pixs, ctl, addr); // cursor cell
            slot(8'h20, 5'd0, 0, 0, 0, 0, 0, 0, 0, 8'h00, pixs, ctl, addr);
            slot(8'h20, 5'd0, 0, 0, 0, 0, 0, 0, 0, 8'h00, pixs, ctl, addr); // cursor cell output
            exp_px = (f == 2 || f == 3) ? 8'hFF : 8'h00;
            check($sformatf("blink_f%0d_pix", f), {8'd0, pixs}, {8'd0, exp_px});
            check($sformatf("blink_f%0d_de", f), {11'd0, ctl}, 16'h0010);
            $display("blink frame %0d: pix=%h de_o=%b", f, pixs, ctl[4]);
            slot(8'h20, 5'd0, 0, 0, 0, 0, 1, 0, 0, 8'h00, pixs, ctl, addr); // vsync edge
        end

        // ---- reset one clock after a stage-2 load
        do_reset();
        slot(8'h7F, 5'd0, 0, 1, 0, 1, 0, 0, 0, 8'h00, pixs, ctl, addr);
        slot(8'h7F, 5'd0, 0, 1, 0, 0, 0, 0, 0, 8'h00, pixs, ctl, addr);
        video_data = 8'h20; vid_de = 1'b1; vid_hsync = 1'b0;
        ce_pix = 1'b1; char_load = 1'b1;
        tick();
        check("rst_pre_out", {10'd0, pix, de_o, hsync_o, vsync_o, hblank_o, vblank_o}, 16'h0038);
        reset = 1'b1; char_load = 1'b0;
        tick();
        check("rst_outputs", {10'd0, pix, de_o, hsync_o, vsync_o, hblank_o, vblank_o}, 16'h0000);
        check("rst_charaddr", {5'd0, charaddr}, 16'h0000);
        $display("mid-char reset: pix=%b de_o=%b hsync_o=%b charaddr=%h", pix, de_o, hsync_o, charaddr);
        reset = 1'b0; ce_pix = 1'b0;
        tick();
        for (int r = 0; r < 3; r++) begin
            slot(8'h7F, 5'd0, 0, 1, 0, 0, 0, 0, 0, 8'h00, pixs, ctl, addr);
            exp_px = (r == 2) ? 8'hFF : 8'h00;
            check($sformatf("rst_resume%0d_pix", r), {8'd0, pixs}, {8'd0, exp_px});
            check($sformatf("rst_resume%0d_de", r), {15'd0, ctl[4]}, {15'd0, (r == 2)});
            $display("post-reset slot %0d: pix=%h de_o=%b", r, pixs, ctl[4]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
